// File: rtl/detector_conditioner_pkg.sv
// detector_conditioner_pkg: detector bit indices, safe level and default timing constants
package detector_conditioner_pkg;
  localparam int DET_FRONT = 0;
  localparam int DET_LEFT = 1;
  localparam int DET_RIGHT = 2;
  localparam int DET_BACK = 3;
  localparam logic DET_BLOCKED = 1'b1;
  localparam int DEF_STABLE_FRAMES = 3;
  localparam int DEF_TIMEOUT_CYCLES = 10_000_000;
  localparam int DEF_HOLDOFF_CYCLES = 50_000_000;
endpackage

// File: rtl/detector_conditioner_bit_filter.sv
// detector_bit_filter: one detector bit, changes only after STABLE_FRAMES consecutive differing frames
module detector_bit_filter
  import detector_conditioner_pkg::*;
#(
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic raw,
  input  logic valid,
  input  logic force_blk,
  output logic filt,
  output logic fall
);
  logic [3:0] cnt;
  logic hit;
  assign hit = valid && raw != filt && cnt + 4'd1 == 4'(STABLE_FRAMES);
  // fall marks the edge on which filt goes blocked->open from real data, never from a force
  assign fall = hit && !force_blk && !raw;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      filt <= DET_BLOCKED;
      cnt <= 4'd0;
    end else if (force_blk) begin
      filt <= DET_BLOCKED;
      cnt <= 4'd0;
    end else if (valid) begin
      filt <= hit ? raw : filt;
      cnt <= (raw == filt || hit) ? 4'd0 : cnt + 4'd1;
    end
endmodule

// File: rtl/detector_conditioner.sv
// detector_conditioner: glitch-filtered detector levels, fork pulse and link-lost watchdog.
// Define FORK_HOLDOFF_EN to suppress fork pulses for HOLDOFF_CYCLES after each pulse.
module detector_conditioner
  import detector_conditioner_pkg::*;
#(
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] rec_byte,
  input  logic       rec_valid,
  output logic       det_front,
  output logic       det_left,
  output logic       det_right,
  output logic       det_back,
  output logic       fork_pulse,
  output logic       link_lost
);
  logic [23:0] wd_cnt;
  logic [3:0] det, fall;
  logic expire, fork_cond, hold_ok;
  logic unused_bits;
  assign unused_bits = ^rec_byte[7:4];
  // a frame arriving in the expiry cycle wins over the timeout
  assign expire = !rec_valid && wd_cnt == 24'(TIMEOUT_CYCLES - 1);
  for (genvar i = 0; i < 4; i++) begin : g_filt
    detector_bit_filter #(.STABLE_FRAMES(STABLE_FRAMES)) u_filt (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .raw(rec_byte[i]),
      .valid(rec_valid),
      .force_blk(expire),
      .filt(det[i]),
      .fall(fall[i])
    );
  end
  assign det_front = det[DET_FRONT];
  assign det_left = det[DET_LEFT];
  assign det_right = det[DET_RIGHT];
  assign det_back = det[DET_BACK];
  assign fork_cond = (fall[DET_LEFT] || fall[DET_RIGHT]) && !link_lost;
`ifdef FORK_HOLDOFF_EN
  logic [25:0] hold_cnt;
  assign hold_ok = hold_cnt == 26'd0;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) hold_cnt <= 26'd0;
    else if (expire) hold_cnt <= 26'd0;
    else if (fork_cond && hold_ok) hold_cnt <= 26'(HOLDOFF_CYCLES);
    else if (!hold_ok) hold_cnt <= hold_cnt - 26'd1;
`else
  localparam int unused_holdoff = HOLDOFF_CYCLES;
  assign hold_ok = 1'b1;
`endif
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      wd_cnt <= 24'd0;
      link_lost <= 1'b1;
      fork_pulse <= 1'b0;
    end else begin
      wd_cnt <= rec_valid ? 24'd0 : (&wd_cnt ? wd_cnt : wd_cnt + 24'd1);
      link_lost <= expire ? 1'b1 : (rec_valid ? 1'b0 : link_lost);
      fork_pulse <= fork_cond && hold_ok;
    end
endmodule

// File: tb/tb_detector_conditioner.sv
// tb_detector_conditioner: scoreboard bench, every cycle's expected outputs queued at drive time
module tb_detector_conditioner;
  localparam int SF = 3;
  localparam int TO = 50;
  localparam int HO = 20;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] rec_byte = 8'h00;
  logic rec_valid = 1'b0;
  logic det_front, det_left, det_right, det_back, fork_pulse, link_lost;
  typedef struct packed {logic [3:0] det; logic pulse; logic ll;} exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [3:0] m_det;
  int m_cnt[4];
  logic m_ll;
  int m_wd, m_edge, m_last;

  detector_conditioner #(.STABLE_FRAMES(SF), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .rec_byte(rec_byte),
    .rec_valid(rec_valid),
    .det_front(det_front),
    .det_left(det_left),
    .det_right(det_right),
    .det_back(det_back),
    .fork_pulse(fork_pulse),
    .link_lost(link_lost)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [5:0] outs();
    return {det_back, det_right, det_left, det_front, fork_pulse, link_lost};
  endfunction

  function automatic void model_reset();
    m_det = 4'hF;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ll = 1'b1;
    m_wd = 0;
    m_edge = 0;
    m_last = -1000;
    sb.delete();
  endfunction

  task automatic step(input logic v, input logic [7:0] b, input string tag);
    exp_t e, got;
    logic fall, hok;
    rec_valid = v;
    rec_byte = b;
    m_edge++;
    fall = 1'b0;
    e.pulse = 1'b0;
`ifdef FORK_HOLDOFF_EN
    hok = (m_edge - m_last) > HO;
`else
    hok = 1'b1;
`endif
    if (!v && m_wd == TO - 1) begin
      m_det = 4'hF;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ll = 1'b1;
      m_last = -1000;
    end else if (v) begin
      for (int i = 0; i < 4; i++)
        if (b[i] == m_det[i]) m_cnt[i] = 0;
        else if (m_cnt[i] + 1 == SF) begin
          m_det[i] = b[i];
          m_cnt[i] = 0;
          if ((i == 1 || i == 2) && !b[i]) fall = 1'b1;
        end else m_cnt[i]++;
      e.pulse = fall && !m_ll && hok;
      if (e.pulse) m_last = m_edge;
      m_ll = 1'b0;
    end
    m_wd = v ? 0 : m_wd + 1;
    e.det = m_det;
    e.ll = m_ll;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    rec_valid = 1'b0;
    e = sb.pop_front();
    got = outs();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got det=%b pulse=%b ll=%b, expected det=%b pulse=%b ll=%b",
               tag, got.det, got.pulse, got.ll, e.det, e.pulse, e.ll);
    end
    if (fork_pulse) pulses++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (outs() !== 6'b1111_0_1) begin
      errors++;
      $display("FAIL reset_state: got %b, expected %b", outs(), 6'b1111_0_1);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_streak_break();
    pulses = 0;
    step(1'b1, 8'h0F, "streak_f1");
    checks++;
    if (link_lost !== 1'b0) begin
      errors++;
      $display("FAIL link_clear_first_frame: got %b, expected 0", link_lost);
    end
    step(1'b1, 8'h0F, "streak_f2");
    step(1'b1, 8'h0D, "streak_f3");
    repeat (2) step(1'b0, 8'h00, "streak_idle");
    checks++;
    if (det_left !== 1'b1 || pulses != 0) begin
      errors++;
      $display("FAIL streak_break: got det_left=%b pulses=%0d, expected 1 and 0", det_left, pulses);
    end
  endtask

  task automatic test_fork();
    step(1'b1, 8'h0F, "fork_clr");
    pulses = 0;
    step(1'b1, 8'h09, "fork_f1");
    step(1'b1, 8'h09, "fork_f2");
    step(1'b1, 8'h09, "fork_f3");
    checks++;
    if ({det_left, det_right, fork_pulse} !== 3'b001) begin
      errors++;
      $display("FAIL fork_open: got l=%b r=%b pulse=%b, expected 0 0 1", det_left, det_right, fork_pulse);
    end
    repeat (3) step(1'b0, 8'h00, "fork_idle");
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL fork_single_pulse: got %0d pulses, expected 1", pulses);
    end
  endtask

  task automatic test_timeout();
    int n;
    repeat (3) begin
      step(1'b1, 8'h0F, "wd_frame");
      repeat (9) step(1'b0, 8'h00, "wd_gap");
    end
    step(1'b1, 8'h0F, "wd_last");
    pulses = 0;
    n = 0;
    while (link_lost !== 1'b1 && n < 100) begin
      step(1'b0, 8'h00, "wd_wait");
      n++;
    end
    checks++;
    if (n != TO || outs() !== 6'b1111_0_1 || pulses != 0) begin
      errors++;
      $display("FAIL timeout: got %0d cycles outs=%b pulses=%0d, expected %0d cycles outs=111101 pulses=0",
               n, outs(), pulses, TO);
    end
    step(1'b1, 8'h0F, "wd_recover");
    checks++;
    if (link_lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got %b, expected 0", link_lost);
    end
  endtask

  task automatic test_expiry_race();
    step(1'b1, 8'h0F, "race_start");
    repeat (TO - 1) step(1'b0, 8'h00, "race_gap");
    step(1'b1, 8'h0F, "race_frame");
    step(1'b0, 8'h00, "race_after");
    checks++;
    if (link_lost !== 1'b0) begin
      errors++;
      $display("FAIL expiry_race: got %b, expected 0", link_lost);
    end
  endtask

  task automatic test_reset_midstreak();
    repeat (3) step(1'b1, 8'h09, "rst_open");
    step(1'b1, 8'h0E, "rst_s1");
    step(1'b1, 8'h0E, "rst_s2");
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 6'b1111_0_1) begin
      errors++;
      $display("FAIL async_reset: got %b, expected %b", outs(), 6'b1111_0_1);
    end
    #3 rst_n = 1'b1;
    model_reset();
    step(1'b1, 8'h0E, "post_rst1");
    step(1'b1, 8'h0E, "post_rst2");
    checks++;
    if (det_front !== 1'b1) begin
      errors++;
      $display("FAIL streak_discarded: got det_front=%b, expected 1", det_front);
    end
    step(1'b1, 8'h0E, "post_rst3");
    checks++;
    if (det_front !== 1'b0) begin
      errors++;
      $display("FAIL streak_after_reset: got det_front=%b, expected 0", det_front);
    end
  endtask

  task automatic left_events(input int gap, input string tag);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, ((k / 3) % 2 == 0) ? 8'h0F : 8'h0D, tag);
      repeat (gap) step(1'b0, 8'h00, tag);
    end
    repeat (3) step(1'b0, 8'h00, tag);
  endtask

  task automatic test_holdoff();
    int want_near;
`ifdef FORK_HOLDOFF_EN
    want_near = 1;
`else
    want_near = 2;
`endif
    pulses = 0;
    left_events(1, "hold_near");
    checks++;
    if (pulses != want_near) begin
      errors++;
      $display("FAIL holdoff_near: got %0d pulses, expected %0d", pulses, want_near);
    end
    pulses = 0;
    left_events(4, "hold_far");
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL holdoff_far: got %0d pulses, expected 2", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_streak_break();
    test_fork();
    test_timeout();
    test_expiry_race();
    test_reset_midstreak();
    test_holdoff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
